// File: rtl/msd_pkg.sv
// Shared types and constants for the memory-side command sequencer:
// command encoding, request op encoding, address field positions, default timing.
package msd_pkg;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT0 = 3'd1,
    CMD_ACT1 = 3'd2,
    CMD_RD0  = 3'd3,
    CMD_RD1  = 3'd4,
    CMD_WR0  = 3'd5,
    CMD_WR1  = 3'd6,
    CMD_PRE  = 3'd7
  } cmd_type_e;

  localparam logic [1:0] OP_READ    = 2'd0;
  localparam logic [1:0] OP_WRITE   = 2'd1;
  localparam logic [1:0] OP_FETCH   = 2'd2;
  localparam logic [1:0] OP_ILLEGAL = 2'd3;

  localparam int unsigned ADDR_W   = 36;
  localparam int unsigned ROW_MSB  = 33;
  localparam int unsigned ROW_LSB  = 18;
  localparam int unsigned COLH_MSB = 17;
  localparam int unsigned COLH_LSB = 12;
  localparam int unsigned BA_MSB   = 11;
  localparam int unsigned BA_LSB   = 10;
  localparam int unsigned BG_MSB   = 9;
  localparam int unsigned BG_LSB   = 7;
  localparam int unsigned CH_BIT   = 6;
  localparam int unsigned COLL_MSB = 5;
  localparam int unsigned COLL_LSB = 2;

  localparam int unsigned ROW_W = ROW_MSB - ROW_LSB + 1;
  localparam int unsigned BA_W  = BA_MSB - BA_LSB + 1;
  localparam int unsigned BG_W  = BG_MSB - BG_LSB + 1;
  localparam int unsigned COL_W = (COLH_MSB - COLH_LSB + 1) + (COLL_MSB - COLL_LSB + 1);

  localparam int unsigned DEF_TRCD   = 39;
  localparam int unsigned DEF_TRAS   = 76;
  localparam int unsigned DEF_TRP    = 39;
  localparam int unsigned DEF_TRTP   = 18;
  localparam int unsigned DEF_TCWL   = 38;
  localparam int unsigned DEF_TBURST = 8;
  localparam int unsigned DEF_TWR    = 48;

  localparam int unsigned CNT_W     = 8;
  localparam int unsigned MAX_DELAY = 255;

  typedef struct packed {
    logic             ch;
    logic [BG_W-1:0]  bg;
    logic [BA_W-1:0]  ba;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } cmd_addr_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/msd_addr_decode.sv
// Combinational split of a physical address into channel/bank-group/bank/row/column.
module msd_addr_decode
  import msd_pkg::*;
(
  input  logic [ADDR_W-1:0] addr_i,
  output logic              channel_o,
  output logic [BG_W-1:0]   bg_o,
  output logic [BA_W-1:0]   ba_o,
  output logic [ROW_W-1:0]  row_o,
  output logic [COL_W-1:0]  col_o
);

  // Top two and bottom two address bits carry no DRAM coordinate.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[ADDR_W-1:ROW_MSB+1], addr_i[COLL_LSB-1:0]};

  assign channel_o = addr_i[CH_BIT];
  assign bg_o      = addr_i[BG_MSB:BG_LSB];
  assign ba_o      = addr_i[BA_MSB:BA_LSB];
  assign row_o     = addr_i[ROW_MSB:ROW_LSB];
  assign col_o     = {addr_i[COLH_MSB:COLH_LSB], addr_i[COLL_MSB:COLL_LSB]};

endmodule

// File: rtl/msd_cmd_sequencer.sv
// Closed-page, single-transaction DRAM command sequencer: ACT0/ACT1, CAS0/CAS1, PRE,
// with one shared down-counter timing the wait states between them.
module msd_cmd_sequencer
  import msd_pkg::*;
#(
  parameter int unsigned TRCD   = DEF_TRCD,
  parameter int unsigned TRAS   = DEF_TRAS,
  parameter int unsigned TRP    = DEF_TRP,
  parameter int unsigned TRTP   = DEF_TRTP,
  parameter int unsigned TCWL   = DEF_TCWL,
  parameter int unsigned TBURST = DEF_TBURST,
  parameter int unsigned TWR    = DEF_TWR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              cmd_valid,
  output logic [2:0]        cmd_type,
  output logic              cmd_channel,
  output logic [BG_W-1:0]   cmd_bg,
  output logic [BA_W-1:0]   cmd_ba,
  output logic [ROW_W-1:0]  cmd_row,
  output logic [COL_W-1:0]  cmd_col,
  output logic              err_op,
  output logic              busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ACT0, S_ACT1, S_WAIT_RCD, S_CAS0, S_CAS1, S_WAIT_PRE, S_PRE, S_WAIT_RP
  } state_e;

  // PRE never lands before CAS1 has gone out, even when TRAS and post are tiny.
  localparam int unsigned PRE_RD    = max3(TRAS, TRCD + TRTP, TRCD + 2);
  localparam int unsigned PRE_WR    = max3(TRAS, TRCD + TCWL + TBURST + TWR, TRCD + 2);
  localparam int unsigned LD_RCD    = TRCD - 2;
  localparam int unsigned LD_PRE_RD = PRE_RD - TRCD - 2;
  localparam int unsigned LD_PRE_WR = PRE_WR - TRCD - 2;
  localparam int unsigned LD_RP     = TRP - 1;

  if (TRCD < 2 || TRP < 1 || TRCD > MAX_DELAY || TRAS > MAX_DELAY || TRP > MAX_DELAY ||
      TRTP > MAX_DELAY || TCWL > MAX_DELAY || TBURST > MAX_DELAY || TWR > MAX_DELAY ||
      LD_PRE_WR > MAX_DELAY || LD_PRE_RD > MAX_DELAY) begin : g_bad_timing
    $error("msd_cmd_sequencer: illegal timing parameters");
  end

  localparam logic [CNT_W-1:0] LD_RCD_C    = CNT_W'(LD_RCD);
  localparam logic [CNT_W-1:0] LD_PRE_RD_C = CNT_W'(LD_PRE_RD);
  localparam logic [CNT_W-1:0] LD_PRE_WR_C = CNT_W'(LD_PRE_WR);
  localparam logic [CNT_W-1:0] LD_RP_C     = CNT_W'(LD_RP);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  cmd_addr_t        fld_q, fld_d;
  logic             err_q, err_d;
  cmd_type_e        cmd_cur;
  logic [CNT_W-1:0] ld_pre;
  logic             is_wr;
  cmd_addr_t        dec;

  msd_addr_decode u_dec (
    .addr_i   (req_addr),
    .channel_o(dec.ch),
    .bg_o     (dec.bg),
    .ba_o     (dec.ba),
    .row_o    (dec.row),
    .col_o    (dec.col)
  );

  assign is_wr  = (op_q == OP_WRITE);
  assign ld_pre = is_wr ? LD_PRE_WR_C : LD_PRE_RD_C;

  // NOTE: every register here is small control state, so all of it is reset;
  // non-blocking assignments keep the whole update atomic at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_READ;
      fld_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      fld_q   <= fld_d;
      err_q   <= err_d;
    end
  end

  // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    fld_d   = fld_q;
    err_d   = 1'b0;
    cmd_cur = CMD_NOP;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_op == OP_ILLEGAL) begin
            err_d = 1'b1;
          end else begin
            op_d    = req_op;
            fld_d   = dec;
            state_d = S_ACT0;
          end
        end
      end
      S_ACT0: begin
        cmd_cur = CMD_ACT0;
        state_d = S_ACT1;
      end
      S_ACT1: begin
        cmd_cur = CMD_ACT1;
        cnt_d   = LD_RCD_C;
        state_d = (LD_RCD_C == '0) ? S_CAS0 : S_WAIT_RCD;
      end
      S_WAIT_RCD: begin
        if (cnt_q <= 1) begin
          cnt_d   = '0;
          state_d = S_CAS0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_CAS0: begin
        cmd_cur = is_wr ? CMD_WR0 : CMD_RD0;
        state_d = S_CAS1;
      end
      S_CAS1: begin
        cmd_cur = is_wr ? CMD_WR1 : CMD_RD1;
        cnt_d   = ld_pre;
        state_d = (ld_pre == '0) ? S_PRE : S_WAIT_PRE;
      end
      S_WAIT_PRE: begin
        if (cnt_q <= 1) begin
          cnt_d   = '0;
          state_d = S_PRE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_PRE: begin
        cmd_cur = CMD_PRE;
        cnt_d   = LD_RP_C;
        state_d = (LD_RP_C == '0) ? S_IDLE : S_WAIT_RP;
      end
      S_WAIT_RP: begin
        if (cnt_q <= 1) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign err_op      = err_q;
  assign cmd_valid   = (cmd_cur != CMD_NOP);
  assign cmd_type    = cmd_cur;
  assign cmd_channel = busy ? fld_q.ch  : 1'b0;
  assign cmd_bg      = busy ? fld_q.bg  : '0;
  assign cmd_ba      = busy ? fld_q.ba  : '0;
  assign cmd_row     = busy ? fld_q.row : '0;
  assign cmd_col     = busy ? fld_q.col : '0;

endmodule

// File: tb/tb_msd_cmd_sequencer.sv
// Directed bench for msd_cmd_sequencer: expected commands are queued per request and
// matched against the command stream; a second instance covers the minimum-timing corner.
module tb_msd_cmd_sequencer;
  import msd_pkg::*;

  localparam int unsigned TRCD = 39, TRAS = 76, TRP = 39, TRTP = 18;
  localparam int unsigned TCWL = 38, TBURST = 8, TWR = 48;

  typedef struct {
    int unsigned at;
    logic [2:0]  typ;
    logic        ch;
    logic [2:0]  bg;
    logic [1:0]  ba;
    logic [15:0] row;
    logic [9:0]  col;
  } exp_t;

  logic clk;
  logic rst;
  logic req_valid, req_ready, cmd_valid, cmd_channel, err_op, busy;
  logic [1:0] req_op;
  logic [35:0] req_addr;
  logic [2:0] cmd_type, cmd_bg;
  logic [1:0] cmd_ba;
  logic [15:0] cmd_row;
  logic [9:0] cmd_col;

  logic c_req_valid, c_req_ready, c_cmd_valid, c_cmd_channel, c_err_op, c_busy;
  logic [1:0] c_req_op;
  logic [35:0] c_req_addr;
  logic [2:0] c_cmd_type, c_cmd_bg;
  logic [1:0] c_cmd_ba;
  logic [15:0] c_cmd_row;
  logic [9:0] c_cmd_col;

  exp_t exp_q[$];
  int unsigned act0_q[$];
  int unsigned edge_n = 0;
  int unsigned cur = 0;
  int n_checks = 0;
  int n_errors = 0;

  msd_cmd_sequencer u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_channel(cmd_channel),
    .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .err_op(err_op), .busy(busy)
  );

  msd_cmd_sequencer #(.TRCD(2), .TRAS(3), .TRP(1), .TRTP(1)) u_corner (
    .clk(clk), .rst(rst),
    .req_valid(c_req_valid), .req_ready(c_req_ready), .req_op(c_req_op), .req_addr(c_req_addr),
    .cmd_valid(c_cmd_valid), .cmd_type(c_cmd_type), .cmd_channel(c_cmd_channel),
    .cmd_bg(c_cmd_bg), .cmd_ba(c_cmd_ba), .cmd_row(c_cmd_row), .cmd_col(c_cmd_col),
    .err_op(c_err_op), .busy(c_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and reconcile the command stream with the scoreboard.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cur = edge_n + 1;
    if (cmd_valid) begin
      if (cmd_type == CMD_ACT0) act0_q.push_back(cur);
      if (exp_q.size() == 0) begin
        check("unexpected_cmd", {29'd0, cmd_type}, CMD_NOP);
      end else begin
        e = exp_q.pop_front();
        check("cmd_at", cur, e.at);
        check("cmd_type", {29'd0, cmd_type}, {29'd0, e.typ});
        check("cmd_row", {16'd0, cmd_row}, {16'd0, e.row});
        check("cmd_col", {22'd0, cmd_col}, {22'd0, e.col});
        check("cmd_bank", {26'd0, cmd_channel, cmd_bg, cmd_ba}, {26'd0, e.ch, e.bg, e.ba});
      end
    end else begin
      check("idle_type_nop", {29'd0, cmd_type}, CMD_NOP);
      if (exp_q.size() != 0 && exp_q[0].at <= cur) begin
        check("missed_cmd", {31'd0, cmd_valid}, 1);
        void'(exp_q.pop_front());
      end
    end
    check("ready_only_idle", {31'd0, req_ready}, {31'd0, ~busy});
  endtask

  task automatic push_txn(input int unsigned e, input logic [1:0] op, input logic [35:0] addr,
                          output int unsigned ready_at);
    int unsigned post, pre_off, m;
    logic wr;
    exp_t x;
    wr      = (op == 2'd1);
    post    = wr ? (TCWL + TBURST + TWR) : TRTP;
    m       = (TRAS > TRCD + post) ? TRAS : TRCD + post;
    pre_off = (m > TRCD + 2) ? m : TRCD + 2;
    x.ch  = addr[6];
    x.bg  = addr[9:7];
    x.ba  = addr[11:10];
    x.row = addr[33:18];
    x.col = {addr[17:12], addr[5:2]};
    x.at = e + 1;               x.typ = CMD_ACT0;                exp_q.push_back(x);
    x.at = e + 2;               x.typ = CMD_ACT1;                exp_q.push_back(x);
    x.at = e + 1 + TRCD;        x.typ = wr ? CMD_WR0 : CMD_RD0;  exp_q.push_back(x);
    x.at = e + 2 + TRCD;        x.typ = wr ? CMD_WR1 : CMD_RD1;  exp_q.push_back(x);
    x.at = e + 1 + pre_off;     x.typ = CMD_PRE;                 exp_q.push_back(x);
    ready_at = e + 1 + pre_off + TRP;
  endtask

  // Called at a falling edge while idle; returns after the accepting edge has passed.
  task automatic start_req(input logic [1:0] op, input logic [35:0] addr, input bit hold,
                           output int unsigned ready_at);
    int unsigned e;
    check("ready_before_req", {31'd0, req_ready}, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    e = edge_n + 1;
    push_txn(e, op, addr, ready_at);
    step();
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int unsigned ready_at);
    int n;
    n = 0;
    while (!req_ready && n < 400) begin
      step();
      n++;
    end
    check({tag, "_ready_at"}, req_ready ? cur : 32'd0, ready_at);
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int unsigned r;
    logic [2:0] corner_seq [5];
    corner_seq[0] = CMD_ACT0; corner_seq[1] = CMD_ACT1; corner_seq[2] = CMD_RD0;
    corner_seq[3] = CMD_RD1;  corner_seq[4] = CMD_PRE;

    rst = 1'b1;
    req_valid = 1'b0; req_op = 2'd0; req_addr = '0;
    c_req_valid = 1'b0; c_req_op = 2'd0; c_req_addr = '0;
    step();
    check("rst_ready", {31'd0, req_ready}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_cmd_valid", {31'd0, cmd_valid}, 0);
    check("rst_err", {31'd0, err_op}, 0);
    check("rst_row", {16'd0, cmd_row}, 0);
    rst = 1'b0;
    step();
    step();

    // Read and fetch with default timing share one command shape.
    start_req(2'd0, 36'h0_1234_5680, 1'b0, r);
    wait_ready("read", r);
    start_req(2'd2, 36'h0_1234_5680, 1'b0, r);
    wait_ready("fetch", r);

    // Illegal op: one-cycle error pulse, still idle.
    req_valid = 1'b1; req_op = 2'd3; req_addr = 36'h0_FFFF_FFFC;
    step();
    req_valid = 1'b0;
    check("illegal_err_pulse", {31'd0, err_op}, 1);
    check("illegal_no_cmd", {31'd0, cmd_valid}, 0);
    check("illegal_ready", {31'd0, req_ready}, 1);
    step();
    check("illegal_err_clear", {31'd0, err_op}, 0);
    check("illegal_row_zero", {16'd0, cmd_row}, 0);
    step();

    // Write, with the ignored address bits set to ones.
    start_req(2'd1, 36'hF_ABCD_EF7F, 1'b0, r);
    wait_ready("write", r);

    // Back-to-back reads with req_valid held; the accepting IDLE cycle separates PRE+TRP
    // from the next ACT0.
    act0_q.delete();
    start_req(2'd0, 36'h0_0004_0040, 1'b1, r);
    req_addr = 36'h0_0008_0480;
    wait_ready("b2b0", r);
    start_req(2'd0, 36'h0_0008_0480, 1'b1, r);
    req_addr = 36'h3_FFFF_FFFF;
    wait_ready("b2b1", r);
    start_req(2'd0, 36'h3_FFFF_FFFF, 1'b0, r);
    wait_ready("b2b2", r);
    check("b2b_act0_count", act0_q.size(), 3);
    if (act0_q.size() == 3) begin
      check("b2b_gap0", act0_q[1] - act0_q[0], TRAS + TRP + 1);
      check("b2b_gap1", act0_q[2] - act0_q[1], TRAS + TRP + 1);
    end

    // Reset while waiting for tRCD: everything clears at once and the read is abandoned.
    start_req(2'd0, 36'h0_1234_5680, 1'b0, r);
    step(); step(); step();
    check("mid_busy", {31'd0, busy}, 1);
    check("mid_row", {16'd0, cmd_row}, 32'h048D);
    #2 rst = 1'b1;
    #1;
    check("async_busy", {31'd0, busy}, 0);
    check("async_ready", {31'd0, req_ready}, 1);
    check("async_row", {16'd0, cmd_row}, 0);
    check("async_bg", {29'd0, cmd_bg}, 0);
    exp_q.delete();
    step(); step();
    rst = 1'b0;
    start_req(2'd0, 36'h0_0ABC_D3C4, 1'b0, r);
    wait_ready("post_reset", r);

    // Minimum-timing instance: five commands on consecutive cycles.
    check("corner_ready0", {31'd0, c_req_ready}, 1);
    c_req_valid = 1'b1; c_req_op = 2'd0; c_req_addr = 36'h0_1234_5680;
    step();
    c_req_valid = 1'b0;
    check("corner_row", {16'd0, c_cmd_row}, 32'h048D);
    check("corner_col", {22'd0, c_cmd_col}, 32'h050);
    check("corner_bank", {26'd0, c_cmd_channel, c_cmd_bg, c_cmd_ba}, {26'd0, 1'b0, 3'd5, 2'd1});
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      check("corner_valid", {31'd0, c_cmd_valid}, 1);
      check("corner_type", {29'd0, c_cmd_type}, {29'd0, corner_seq[i]});
    end
    check("corner_busy_at_pre", {30'd0, c_busy, c_err_op}, 32'h2);
    step();
    check("corner_ready_after_pre", {31'd0, c_req_ready}, 1);
    check("corner_idle_valid", {31'd0, c_cmd_valid}, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
